// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : MEM/WB pipeline stage register with valid/ready handshake,
//               flush, qualified write-back outputs and a saturating stall
//               counter. Define PIPE_STAGE_REG_SKID_EN to add a skid entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] wb_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] wb_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [15:0]       stall_cnt_o
);

    logic              w_valid;
    logic              w_ready;
    logic              w_accept;
    logic [CTRL_W-1:0] r_wb;
    logic [DATA_W-1:0] r_mem;
    logic [DATA_W-1:0] r_alu;
    logic [ADDR_W-1:0] r_rd;
    logic [15:0]       r_stall_cnt;

`ifdef PIPE_STAGE_REG_SKID_EN
    localparam logic [1:0] C_ST_EMPTY = 2'd0;
    localparam logic [1:0] C_ST_ONE   = 2'd1;
    localparam logic [1:0] C_ST_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_retire;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_main_from_skid;
    logic [CTRL_W-1:0] r_skid_wb;
    logic [DATA_W-1:0] r_skid_mem;
    logic [DATA_W-1:0] r_skid_alu;
    logic [ADDR_W-1:0] r_skid_rd;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= C_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = C_ST_EMPTY;
        end else begin
            case (r_state)
                C_ST_EMPTY: if (w_accept) w_state_nxt = C_ST_ONE;
                C_ST_ONE: begin
                    if (w_accept && !w_retire)      w_state_nxt = C_ST_TWO;
                    else if (!w_accept && w_retire) w_state_nxt = C_ST_EMPTY;
                end
                C_ST_TWO: if (w_retire) w_state_nxt = C_ST_ONE;
                default:  w_state_nxt = C_ST_EMPTY;
            endcase
        end
    end

    // ready_o comes straight from state, so it is a registered !skid_valid.
    always_comb begin
        w_valid          = (r_state != C_ST_EMPTY);
        w_ready          = (r_state != C_ST_TWO);
        w_accept         = valid_i && w_ready && !flush_i;
        w_retire         = w_valid && ready_i && !flush_i;
        w_load_main      = w_accept && ((r_state == C_ST_EMPTY) ||
                                        ((r_state == C_ST_ONE) && w_retire));
        w_load_skid      = w_accept && (r_state == C_ST_ONE) && !w_retire;
        w_main_from_skid = w_retire && (r_state == C_ST_TWO);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wb       <= '0;
            r_mem      <= '0;
            r_alu      <= '0;
            r_rd       <= '0;
            r_skid_wb  <= '0;
            r_skid_mem <= '0;
            r_skid_alu <= '0;
            r_skid_rd  <= '0;
        end else begin
            if (w_load_main) begin
                r_wb  <= wb_i;
                r_mem <= mem_data_i;
                r_alu <= alu_data_i;
                r_rd  <= rd_addr_i;
            end else if (w_main_from_skid) begin
                r_wb  <= r_skid_wb;
                r_mem <= r_skid_mem;
                r_alu <= r_skid_alu;
                r_rd  <= r_skid_rd;
            end
            if (w_load_skid) begin
                r_skid_wb  <= wb_i;
                r_skid_mem <= mem_data_i;
                r_skid_alu <= alu_data_i;
                r_skid_rd  <= rd_addr_i;
            end
        end
    end
`else
    logic r_valid;

    assign w_valid  = r_valid;
    assign w_ready  = !r_valid || ready_i;
    assign w_accept = valid_i && w_ready && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_wb    <= '0;
            r_mem   <= '0;
            r_alu   <= '0;
            r_rd    <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_wb    <= wb_i;
            r_mem   <= mem_data_i;
            r_alu   <= alu_data_i;
            r_rd    <= rd_addr_i;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !ready_i && !flush_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign ready_o      = w_ready;
    assign valid_o      = w_valid;
    assign wb_o         = r_wb;
    assign mem_to_reg_o = r_wb[0];
    assign rd_addr_o    = r_rd;
    assign wb_data_o    = r_wb[0] ? r_mem : r_alu;
    assign reg_write_o  = w_valid && r_wb[1] && (r_rd != '0);
    assign stall_cnt_o  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Self-checking bench for pipe_stage_reg: scoreboard of accepted entries,
// directed write-back cases, stall/flush, saturation and async reset.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
    } entry_t;

    logic        clk;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  wb_i;
    logic [31:0] mem_data_i;
    logic [31:0] alu_data_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  wb_o;
    logic        reg_write_o;
    logic        mem_to_reg_o;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_addr_o;
    logic [15:0] stall_cnt_o;

    entry_t      q[$];
    logic [15:0] m_stall;
    int          n_checks;
    int          n_errors;

    pipe_stage_reg #(.DATA_W(32), .ADDR_W(5), .CTRL_W(2)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .wb_i         (wb_i),
        .mem_data_i   (mem_data_i),
        .alu_data_i   (alu_data_i),
        .rd_addr_i    (rd_addr_i),
        .flush_i      (flush_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .wb_o         (wb_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .wb_data_o    (wb_data_o),
        .rd_addr_o    (rd_addr_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at a falling edge; drives inputs, checks outputs, models the rising edge.
    task automatic tick(input logic v, input logic [1:0] wb, input logic [31:0] mem,
                        input logic [31:0] alu, input logic [4:0] rd,
                        input logic rdy, input logic fl);
        logic   exp_valid;
        logic   exp_ready;
        logic   acc;
        logic   ret;
        entry_t e;
        entry_t n;
        valid_i    = v;
        wb_i       = wb;
        mem_data_i = mem;
        alu_data_i = alu;
        rd_addr_i  = rd;
        ready_i    = rdy;
        flush_i    = fl;
        #1;
        exp_valid = (q.size() != 0);
`ifdef PIPE_STAGE_REG_SKID_EN
        exp_ready = (q.size() < 2);
`else
        exp_ready = !exp_valid || rdy;
`endif
        check_val("valid_o", valid_o, exp_valid);
        check_val("ready_o", ready_o, exp_ready);
        check_val("stall_cnt_o", stall_cnt_o, m_stall);
        if (exp_valid) begin
            e = q[0];
            check_val("wb_o", wb_o, e.wb);
            check_val("rd_addr_o", rd_addr_o, e.rd);
            check_val("wb_data_o", wb_data_o, e.wb[0] ? e.mem : e.alu);
            check_val("mem_to_reg_o", mem_to_reg_o, e.wb[0]);
            check_val("reg_write_o", reg_write_o, e.wb[1] && (e.rd != 5'd0));
        end else begin
            check_val("reg_write_o_idle", reg_write_o, 1'b0);
        end
        acc = v && exp_ready && !fl;
        ret = exp_valid && rdy && !fl;
        if (exp_valid && !rdy && !fl && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        if (fl) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) begin
                n.wb = wb; n.mem = mem; n.alu = alu; n.rd = rd;
                q.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid_o"}, valid_o, 1'b0);
        check_val({tag, "_ready_o"}, ready_o, 1'b1);
        check_val({tag, "_reg_write_o"}, reg_write_o, 1'b0);
        check_val({tag, "_wb_o"}, wb_o, 2'b00);
        check_val({tag, "_rd_addr_o"}, rd_addr_o, 5'd0);
        check_val({tag, "_wb_data_o"}, wb_data_o, 32'd0);
        check_val({tag, "_stall_cnt_o"}, stall_cnt_o, 16'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_stall    = 16'd0;
        rst_n_i    = 1'b1;
        valid_i    = 1'b0;
        wb_i       = 2'b00;
        mem_data_i = 32'd0;
        alu_data_i = 32'd0;
        rd_addr_i  = 5'd0;
        ready_i    = 1'b0;
        flush_i    = 1'b0;
        #2 rst_n_i = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;

        // Directed write-back cases
        tick(1, 2'b10, 32'h0, 32'h1234, 5'd5, 1, 0);
        tick(1, 2'b10, 32'h0, 32'h1234, 5'd0, 1, 0);
        tick(1, 2'b11, 32'hDEADBEEF, 32'h4, 5'd7, 1, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 1, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 1, 0);

        // Stall with A then B presented, then drain
        tick(1, 2'b10, 32'h0, 32'hAAAA, 5'd1, 0, 0);
        tick(1, 2'b11, 32'hBBBB, 32'h0, 5'd2, 0, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 1, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 1, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 1, 0);

        // Fill, then flush while stalled
        tick(1, 2'b10, 32'h0, 32'h11, 5'd3, 0, 0);
        tick(1, 2'b10, 32'h0, 32'h22, 5'd4, 0, 0);
        tick(1, 2'b10, 32'h0, 32'h33, 5'd6, 0, 1);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 1), 2'($urandom), $urandom, $urandom,
                 5'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
        end

        // Long stall to saturation
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1);
        tick(1, 2'b10, 32'h0, 32'h5A5A, 5'd9, 0, 0);
        valid_i = 1'b0;
        ready_i = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            @(negedge clk);
        end
        check_val("stall_saturated", stall_cnt_o, 16'hFFFF);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 0);

        // Asynchronous reset mid-stall
        #2 rst_n_i = 1'b0;
        #1 check_reset_outputs("async_reset");
        q.delete();
        m_stall = 16'd0;
        @(negedge clk);
        rst_n_i = 1'b1;
        tick(1, 2'b11, 32'hCAFE, 32'h1, 5'd8, 1, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 1, 0);
        tick(0, 2'b00, 32'h0, 32'h0, 5'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
